// File: rtl/tff_toggle_ctrl.sv
// ============================================================================
//  Module   : tff_toggle_ctrl
//  Purpose  : Drives the t input of a single T flip-flop to produce a square
//             wave with a programmable half-period, either as a finite burst
//             of toggles or free-running until stopped.
//  Option   : TFF_TOGGLE_CTRL_PARK_EN - park q low at the end of every burst
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tff_toggle_ctrl #(
  parameter int HP_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic [HP_W-1:0]  half_period,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             q_fb,
  output logic             t,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] toggles_left
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_PARK      = 3'd2,
    S_PARK_WAIT = 3'd3,
    S_DONE      = 3'd4
  } state_t;

`ifdef TFF_TOGGLE_CTRL_PARK_EN
  localparam state_t RUN_EXIT = S_PARK;
`else
  localparam state_t RUN_EXIT = S_DONE;
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
`endif

  state_t          state;
  logic [HP_W-1:0] hp;
  logic [HP_W-1:0] cnt;
  logic            free_run;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      hp           <= '0;
      cnt          <= '0;
      free_run     <= 1'b0;
      t            <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      toggles_left <= '0;
    end else begin
      t    <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          // A simultaneous stop suppresses both the start and its error.
          if (start && !stop) begin
            if (half_period == '0) begin
              err <= 1'b1;
            end else begin
              hp           <= half_period;
              cnt          <= half_period - HP_W'(1);
              toggles_left <= burst_len;
              free_run     <= (burst_len == '0);
              busy         <= 1'b1;
              state        <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (stop) begin
            state <= RUN_EXIT;
          end else if (cnt == '0) begin
            t   <= 1'b1;
            cnt <= hp - HP_W'(1);
            if (!free_run) begin
              toggles_left <= toggles_left - CNT_W'(1);
              if (toggles_left == CNT_W'(1)) begin
                state <= RUN_EXIT;
              end
            end
          end else begin
            cnt <= cnt - HP_W'(1);
          end
        end

`ifdef TFF_TOGGLE_CTRL_PARK_EN
        // A pulse still in flight on t toggles q at this same edge, so the
        // level q will settle to is q_fb ^ t.
        S_PARK: begin
          if (q_fb ^ t) begin
            t     <= 1'b1;
            state <= S_PARK_WAIT;
          end else begin
            state <= S_DONE;
          end
        end

        S_PARK_WAIT: begin
          state <= S_DONE;
        end
`endif

        S_DONE: begin
          done         <= 1'b1;
          busy         <= 1'b0;
          toggles_left <= '0;
          cnt          <= '0;
          state        <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tff_toggle_ctrl.sv
// Directed bench for tff_toggle_ctrl with a behavioural T flip-flop on q_fb;
// expected outputs are queued per clock and compared after each edge.
`default_nettype none

module tb_tff_toggle_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tff_rstn = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] half_period = 8'd0;
  logic [7:0] burst_len = 8'd0;
  logic       q_fb;
  logic       t, busy, done, err;
  logic [7:0] toggles_left;

  int   passed = 0;
  int   total  = 0;
  logic qexp   = 1'b0;

  typedef struct {
    logic       t, busy, done, err;
    logic [7:0] tl;
    string      tag;
  } exp_t;
  exp_t sb[$];

  tff_toggle_ctrl #(.HP_W(8), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop),
    .half_period(half_period), .burst_len(burst_len), .q_fb(q_fb),
    .t(t), .busy(busy), .done(done), .err(err), .toggles_left(toggles_left)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge tff_rstn) begin
    if (!tff_rstn) q_fb <= 1'b0;
    else if (t)    q_fb <= ~q_fb;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input logic et, input logic eb, input logic ed, input logic ee,
                      input logic [7:0] etl, input string tag);
    exp_t e;
    sb.push_back('{t: et, busy: eb, done: ed, err: ee, tl: etl, tag: tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".t"},    8'(t),    8'(e.t));
    chk({e.tag, ".busy"}, 8'(busy), 8'(e.busy));
    chk({e.tag, ".done"}, 8'(done), 8'(e.done));
    chk({e.tag, ".err"},  8'(err),  8'(e.err));
    chk({e.tag, ".tl"},   toggles_left, e.tl);
  endtask

  // One burst: stop sampled at edge stop_at, reset dropped after edge abort_at
  // (0 disables either). Expected t follows the k % hp == 0 pulse rule.
  task automatic burst(input int hp, input int n, input int stop_at, input int abort_at);
    int         pulses;
    int         k;
    logic       et;
    logic       tp;
    logic [7:0] tl;
    bit         fin;
    pulses = 0; tp = 1'b0; fin = 1'b0; k = 0; tl = 8'(n);
    half_period = 8'(hp); burst_len = 8'(n); start = 1'b1;
    tick(0, 1, 0, 0, 8'(n), "accept");
    half_period = 8'd7; burst_len = 8'd1;
    while (!fin) begin
      k++;
      start = (k < 3);
      stop  = (k == stop_at);
      if (tp) qexp = ~qexp;
      et = (k == stop_at) ? 1'b0 : ((k % hp) == 0);
      if (et) pulses++;
      tl = (n == 0) ? 8'd0 : 8'(n - pulses);
      tick(et, 1, 0, 0, tl, "run");
      tp = et;
      if (k == abort_at) begin
        #1 rstn = 1'b0;
        #1;
        chk("async.t", 8'(t), 8'd0);
        chk("async.busy", 8'(busy), 8'd0);
        chk("async.tl", toggles_left, 8'd0);
        start = 1'b0; stop = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        chk("abort.q_fb", 8'(q_fb), 8'(qexp));
        return;
      end
      if (k == stop_at || (n != 0 && pulses == n)) fin = 1'b1;
    end
    stop = 1'b0; start = 1'b0;
    if (tp) qexp = ~qexp;
`ifdef TFF_TOGGLE_CTRL_PARK_EN
    if (qexp) begin
      tick(1, 1, 0, 0, tl, "park");
      qexp = ~qexp;
      tick(0, 1, 0, 0, tl, "park_wait");
    end else begin
      tick(0, 1, 0, 0, tl, "park");
    end
`endif
    tick(0, 0, 1, 0, 8'd0, "done");
    tick(0, 0, 0, 0, 8'd0, "idle");
    chk("end.q_fb", 8'(q_fb), 8'(qexp));
  endtask

  initial begin
    // Reset held with start high.
    start = 1'b1; half_period = 8'd3; burst_len = 8'd2;
    repeat (3) tick(0, 0, 0, 0, 8'd0, "reset");
    #1 rstn = 1'b1; tff_rstn = 1'b1; start = 1'b0;
    tick(0, 0, 0, 0, 8'd0, "post_reset");

    // HP=3, N=4: pulses at edges 3,6,9,12, done at 13.
    burst(3, 4, 0, 0);

    // Free-run at HP=1, stopped after five pulses.
    burst(1, 0, 6, 0);

    // Zero half-period rejected, then a valid start accepted.
    half_period = 8'd0; burst_len = 8'd2; start = 1'b1;
    tick(0, 0, 0, 1, 8'd0, "hp0_err");
    start = 1'b0;
    tick(0, 0, 0, 0, 8'd0, "hp0_idle");
    burst(2, 1, 0, 0);

    // Start together with stop: no error, no burst.
    half_period = 8'd0; start = 1'b1; stop = 1'b1;
    tick(0, 0, 0, 0, 8'd0, "start_stop");
    start = 1'b0; stop = 1'b0;
    tick(0, 0, 0, 0, 8'd0, "start_stop_idle");

    // Stop right after the first pulse.
    burst(4, 3, 5, 0);

    // Reset mid-burst while t is high, then a clean two-pulse burst.
    burst(2, 10, 0, 4);
    tick(0, 0, 0, 0, 8'd0, "after_abort");
    burst(2, 2, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
